// File: rtl/besm_pkg.sv
// Shared fetch types and widths.
// Used by fetch_ctl and its bench.
package besm_pkg;

  localparam int ADDR_W = 20;
  localparam int WORD_W = 64;

  typedef enum logic {
    IDLE,
    BUSY
  } fetch_state_t;

  typedef enum logic {
    CUR,
    PRE
  } fetch_tgt_t;

endpackage

// File: rtl/fetch_ctl.sv
// Instruction fetch sequencer with a one-word prefetch buffer.
// Steps tkk through left/right halves and redirects on jump.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   mem_req/addr        read request, held until mem_ack
//   mem_ack/rdata       completion and data [64:1]
//   dc, tkk, pc         current word, half select, word address
//   ir_valid, ir_take   current half valid / consumed
//   jump, jump_addr,    control transfer strobe and target
//   jump_right          target starts at right half
module fetch_ctl
  import besm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 20'h00000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W:1]   mem_rdata,
  output logic [WORD_W:1]   dc,
  output logic              tkk,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_valid,
  input  logic              ir_take,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              jump_right
);

  fetch_state_t      r_state, w_state_n;
  fetch_tgt_t        r_tgt, w_tgt_n;
  logic              r_disc, w_disc_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [WORD_W:1]   r_dc, w_dc_n;
  logic [WORD_W:1]   r_pbuf, w_pbuf_n;
  logic              r_pv, w_pv_n;
  logic              r_irv, w_irv_n;
  logic              r_tkk, w_tkk_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic              w_take;

  assign w_take = ir_take & r_irv;

  always_comb begin
    w_state_n = r_state;
    w_tgt_n   = r_tgt;
    w_disc_n  = r_disc;
    w_addr_n  = r_addr;
    w_dc_n    = r_dc;
    w_pbuf_n  = r_pbuf;
    w_pv_n    = r_pv;
    w_irv_n   = r_irv;
    w_tkk_n   = r_tkk;
    w_pc_n    = r_pc;

    // consumer side: jump beats take
    if (jump) begin
      w_pc_n  = jump_addr;
      w_tkk_n = jump_right;
      w_irv_n = 1'b0;
      w_pv_n  = 1'b0;
    end else if (w_take) begin
      if (!r_tkk) begin
        w_tkk_n = 1'b1;
      end else begin
        w_tkk_n = 1'b0;
        w_pc_n  = r_pc + ADDR_W'(1);
        if (r_pv) begin
          w_dc_n = r_pbuf;
          w_pv_n = 1'b0;
        end else begin
          // in-flight prefetch now holds the new current word
          w_irv_n = 1'b0;
          w_tgt_n = CUR;
        end
      end
    end

    // memory side; buffer view above already includes this cycle's take/jump
    unique case (r_state)
      BUSY: begin
        if (mem_ack) begin
          w_state_n = IDLE;
          w_disc_n  = 1'b0;
          if (!r_disc && !jump) begin
            if (w_tgt_n == CUR) begin
              w_dc_n  = mem_rdata;
              w_irv_n = 1'b1;
            end else begin
              w_pbuf_n = mem_rdata;
              w_pv_n   = 1'b1;
            end
          end
        end else if (jump) begin
          w_disc_n = 1'b1;
        end
      end
      IDLE: begin
        if (!w_irv_n) begin
          w_state_n = BUSY;
          w_addr_n  = w_pc_n;
          w_tgt_n   = CUR;
        end else if (!w_pv_n) begin
          w_state_n = BUSY;
          w_addr_n  = w_pc_n + ADDR_W'(1);
          w_tgt_n   = PRE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tgt   <= CUR;
      r_disc  <= 1'b0;
      r_addr  <= '0;
      r_dc    <= '0;
      r_pbuf  <= '0;
      r_pv    <= 1'b0;
      r_irv   <= 1'b0;
      r_tkk   <= 1'b0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_tgt   <= w_tgt_n;
      r_disc  <= w_disc_n;
      r_addr  <= w_addr_n;
      r_dc    <= w_dc_n;
      r_pbuf  <= w_pbuf_n;
      r_pv    <= w_pv_n;
      r_irv   <= w_irv_n;
      r_tkk   <= w_tkk_n;
      r_pc    <= w_pc_n;
    end
  end

  assign mem_req  = (r_state == BUSY);
  assign mem_addr = r_addr;
  assign dc       = r_dc;
  assign tkk      = r_tkk;
  assign pc       = r_pc;
  assign ir_valid = r_irv;

endmodule

// File: tb/tb_fetch_ctl.sv
// Bench for fetch_ctl: latency memory, half-stream model,
// directed fetch/jump/wrap/reset scenarios.
module tb_fetch_ctl;

  localparam logic [19:0] RPC = 20'h00100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [64:1] mem_rdata = '0;
  logic [64:1] dc;
  logic        tkk;
  logic [19:0] pc;
  logic        ir_valid;
  logic        ir_take = 1'b0;
  logic        jump = 1'b0;
  logic [19:0] jump_addr = '0;
  logic        jump_right = 1'b0;

  int errs = 0;
  int checks = 0;
  int lat = 2;
  int cnt = 0;

  always #5 clk = ~clk;

  fetch_ctl #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dc        (dc),
    .tkk       (tkk),
    .pc        (pc),
    .ir_valid  (ir_valid),
    .ir_take   (ir_take),
    .jump      (jump),
    .jump_addr (jump_addr),
    .jump_right(jump_right)
  );

  function automatic logic [64:1] memf(input logic [19:0] a);
    logic [64:1] b;
    b = 64'hA5A5_A5A5_A5A5_A5A5;
    return b ^ {44'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // memory: acks after lat idle cycles of a held request
  always @(posedge clk) begin
    #1;
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (cnt >= lat) begin
      mem_ack = 1'b1;
      mem_rdata = memf(mem_addr);
      cnt = 0;
    end else begin
      mem_ack = 1'b0;
      cnt++;
    end
  end

  // model: expected half stream plus request log
  logic [19:0] m_pc = RPC;
  logic        m_tkk = 1'b0;
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic [19:0] p_addr = '0;
  logic [19:0] q[$];

  always @(negedge clk) begin
    if (reset) begin
      m_pc = RPC;
      m_tkk = 1'b0;
      p_req = 1'b0;
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_dc", dc, 0);
      chk("rst_tkk", tkk, 0);
      chk("rst_pc", pc, RPC);
      chk("rst_valid", ir_valid, 0);
    end else begin
      if (mem_req) begin
        if (p_req && !p_ack) chk("addr_stable", mem_addr, p_addr);
        else q.push_back(mem_addr);
      end
      p_req = mem_req;
      p_ack = mem_ack;
      p_addr = mem_addr;
      if (ir_valid) begin
        chk("m_pc", pc, m_pc);
        chk("m_tkk", tkk, m_tkk);
        chk("m_dc", dc, memf(m_pc));
      end
      if (jump) begin
        m_pc = jump_addr;
        m_tkk = jump_right;
      end else if (ir_valid && ir_take) begin
        if (m_tkk) begin
          m_tkk = 1'b0;
          m_pc = m_pc + 20'd1;
        end else begin
          m_tkk = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!ir_valid && n < 60) begin
      tick();
      n++;
    end
    chk(nm, ir_valid, 1);
  endtask

  task automatic wait_q(input string nm, input int idx,
                        input logic [19:0] exp);
    int n;
    n = 0;
    while (q.size() <= idx && n < 60) begin
      tick();
      n++;
    end
    if (q.size() > idx) begin
      chk(nm, q[idx], exp);
    end else begin
      checks++;
      errs++;
      $display("FAIL %s: got no request want addr %h", nm, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nj;
    int n;
    logic [19:0] p0;
    logic found;

    repeat (3) tick();
    chk("t0_pc", pc, 20'h00100);
    chk("t0_req", mem_req, 0);
    reset = 1'b0;
    tick();
    chk("t0_first_req", mem_req, 1);
    chk("t0_first_addr", mem_addr, 20'h00100);

    // take every cycle
    ir_take = 1'b1;
    wait_valid("t1_valid");
    chk("t1_dc", dc, 64'hA5A5_A5A5_A5A5_A4A5);
    chk("t1_pc", pc, 20'h00100);
    chk("t1_tkk", tkk, 0);
    tick();
    chk("t1_right", tkk, 1);
    chk("t1_pc2", pc, 20'h00100);
    repeat (12) tick();
    wait_q("t1_a0", 0, 20'h00100);
    wait_q("t1_a1", 1, 20'h00101);
    wait_q("t1_a2", 2, 20'h00102);

    // fill prefetch, then two back-to-back takes
    ir_take = 1'b0;
    wait_valid("t2_valid");
    if (tkk) begin
      ir_take = 1'b1;
      tick();
      ir_take = 1'b0;
      wait_valid("t2_valid2");
    end
    repeat (10) tick();
    p0 = pc;
    chk("t2_left", tkk, 0);
    ir_take = 1'b1;
    tick();
    chk("t2_v1", ir_valid, 1);
    chk("t2_tkk1", tkk, 1);
    tick();
    chk("t2_v2", ir_valid, 1);
    chk("t2_tkk2", tkk, 0);
    chk("t2_pc", pc, p0 + 20'd1);
    ir_take = 1'b0;

    // jump while a prefetch is outstanding
    lat = 4;
    found = 1'b0;
    n = 0;
    while (!found && n < 60) begin
      if (ir_valid && mem_req && !mem_ack) begin
        found = 1'b1;
      end else begin
        ir_take = ir_valid && !mem_req;
        tick();
        n++;
      end
    end
    ir_take = 1'b0;
    chk("t3_setup", found, 1);
    jump = 1'b1;
    jump_addr = 20'h12345;
    jump_right = 1'b1;
    tick();
    jump = 1'b0;
    chk("t3_inval", ir_valid, 0);
    nj = q.size();
    wait_valid("t3_valid");
    chk("t3_tkk", tkk, 1);
    chk("t3_pc", pc, 20'h12345);
    chk("t3_dc", dc, memf(20'h12345));
    wait_q("t3_addr", nj, 20'h12345);

    // jump and take together
    ir_take = 1'b1;
    jump = 1'b1;
    jump_addr = 20'h00200;
    jump_right = 1'b0;
    tick();
    jump = 1'b0;
    ir_take = 1'b0;
    chk("t4_pc", pc, 20'h00200);
    chk("t4_tkk", tkk, 0);
    chk("t4_inval", ir_valid, 0);
    wait_valid("t4_valid");
    chk("t4_pc2", pc, 20'h00200);
    chk("t4_tkk2", tkk, 0);

    // wrap at top of address space
    lat = 2;
    jump = 1'b1;
    jump_addr = 20'hFFFFF;
    jump_right = 1'b1;
    tick();
    jump = 1'b0;
    nj = q.size();
    wait_valid("t5_valid");
    chk("t5_pc", pc, 20'hFFFFF);
    chk("t5_tkk", tkk, 1);
    ir_take = 1'b1;
    tick();
    ir_take = 1'b0;
    chk("t5_wrap_pc", pc, 20'h00000);
    chk("t5_wrap_tkk", tkk, 0);
    wait_valid("t5_valid2");
    chk("t5_dc", dc, memf(20'h00000));
    wait_q("t5_a0", nj, 20'hFFFFF);
    wait_q("t5_a1", nj + 1, 20'h00000);

    // reset while a request is in flight
    found = 1'b0;
    n = 0;
    ir_take = 1'b1;
    while (!found && n < 60) begin
      if (mem_req) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    ir_take = 1'b0;
    chk("t6_setup", found, 1);
    reset = 1'b1;
    #1;
    chk("t6_req", mem_req, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_pc", pc, 20'h00100);
    chk("t6_valid", ir_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    nj = q.size();
    tick();
    chk("t6_req2", mem_req, 1);
    chk("t6_addr2", mem_addr, 20'h00100);
    wait_valid("t6_valid2");
    chk("t6_pc2", pc, 20'h00100);
    chk("t6_dc", dc, 64'hA5A5_A5A5_A5A5_A4A5);
    wait_q("t6_q", nj, 20'h00100);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctl.md
# fetch_ctl

Instruction fetch sequencer feeding the instruction decoder. Fetches 64-bit instruction words from memory over a req/ack port and holds the current word on `dc`. Steps `tkk` through left then right half-instruction and keeps a one-word prefetch buffer. Handles control transfers by redirecting the program counter and discarding stale responses.

## Interface
- `RESET_PC`, 20'h00000, word address loaded into `pc` on reset
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `mem_req`  out  1  read request; held high until `mem_ack`
- `mem_addr`  out  20  word address; stable while `mem_req` high
- `mem_ack`  in  1  one-cycle completion, meaningful only while `mem_req` high (same-cycle ack allowed)
- `mem_rdata`  in  64  read data, valid with `mem_ack`, bit order [64:1]
- `dc`  out  64  current instruction word to decoder, [64:1]
- `tkk`  out  1  0 = left half, 1 = right half
- `pc`  out  20  word address of `dc`
- `ir_valid`  out  1  `dc`/`tkk` hold a valid half-instruction
- `ir_take`  in  1  consumer accepts current half; ignored when `ir_valid`=0
- `jump`  in  1  one-cycle control transfer strobe
- `jump_addr`  in  20  target word address
- `jump_right`  in  1  target starts at right half

## Operation
- State per buffer: current (`dc`, `ir_valid`), prefetch (`pbuf`, `pvalid`); one outstanding request max, tagged `tgt` ∈ {CUR, PRE} plus `discard` flag.
- Request FSM: IDLE, BUSY. IDLE→BUSY when a fetch is needed; BUSY→IDLE on `mem_ack`.
- Fetch priority in IDLE: current empty → fetch `pc` (tgt CUR); else prefetch empty → fetch `pc+1` (tgt PRE); else stay IDLE.
- On ack: `discard`=1 → drop data, clear `discard`; tgt CUR → `dc`←data, `ir_valid`←1; tgt PRE → `pbuf`←data, `pvalid`←1.
- Take at `tkk`=0: `tkk`←1, `ir_valid` stays 1.
- Take at `tkk`=1: `tkk`←0, `pc`←`pc`+1. If `pvalid` → `dc`←`pbuf`, `pvalid`←0, `ir_valid` stays 1. Else `ir_valid`←0; an outstanding PRE request is retagged CUR.
- Jump: `pc`←`jump_addr`, `tkk`←`jump_right`, `ir_valid`←0, `pvalid`←0. Any outstanding request gets `discard`←1; it is not withdrawn and `mem_addr` stays stable.
- Jump has priority over `ir_take` in the same cycle. A jump in the same cycle as an ack discards that ack's data.
- `pc+1` wraps modulo 2^20 (20'hFFFFF → 0).

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `dc`=0, `tkk`=0, `pc`=RESET_PC, `ir_valid`=0, `pvalid`=0, `discard`=0, FSM IDLE.
- First cycle after reset release: `mem_req`=1, `mem_addr`=RESET_PC.
- Ack in cycle N → `ir_valid`=1 in cycle N+1. Next request (prefetch) may issue in N+1.
- Left take in cycle N → right half visible N+1.
- Right take with `pvalid`=1 → next word left half visible N+1 with no bubble.
- Jump in cycle N with no request outstanding → `mem_req` to `jump_addr` in N+1. With a request outstanding → new request the cycle after the stale ack.
- `reset` mid-request: all state cleared immediately; the in-flight ack is the memory's problem, and the memory must also be reset.

## Structure
- Shared package `besm_pkg`: `ADDR_W`=20, `WORD_W`=64, enum `fetch_state_t` {IDLE, BUSY}, enum `fetch_tgt_t` {CUR, PRE}.
- Single module; no sub-module (the one-entry prefetch buffer is inline).
- `dc`/`tkk` connect directly to the decoder's `dc`/`tkk`.

## Test plan
- Reset, RESET_PC=20'h00100, ack after 2 cycles with 64'hA5A5…; take every cycle → halves (100,0),(100,1),(101,0)… and `mem_addr` sequence 100,101,102.
- Back-to-back takes with prefetch full → `ir_valid` stays 1 across word boundary, no bubble.
- Jump to 20'h12345, `jump_right`=1, while a prefetch is outstanding → stale data dropped, next `mem_addr`=12345, first valid half has `tkk`=1, `pc`=12345.
- Jump and `ir_take` in the same cycle → take ignored, `pc`=`jump_addr`.
- `pc`=20'hFFFFF, right take → `pc`=0, `mem_addr`=0.
- Assert `reset` while `mem_req`=1 → all outputs at reset values next edge; re-fetch from RESET_PC.
